// File: rtl/vec_alu_pkg.sv
// rtl/vec_alu_pkg.sv - opcode/subcode constants shared by the vector execute pipeline
package vec_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SMEM = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_VLD  = 4'hC;
  localparam logic [3:0] OP_VST  = 4'hD;
  localparam logic [3:0] OP_DOT  = 4'hE;

  localparam logic [3:0] J_Z    = 4'd0;
  localparam logic [3:0] J_NZ   = 4'd1;
  localparam logic [3:0] J_S    = 4'd2;
  localparam logic [3:0] J_NS   = 4'd3;
  localparam logic [3:0] SUB_ST = 4'd1;

  function automatic logic is_store(input logic [3:0] op, input logic [3:0] sub);
    return ((op == OP_SMEM) || (op == OP_VLD) || (op == OP_VST)) && (sub == SUB_ST);
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// rtl/vec_alu_lane.sv - combinational single-lane add/sub/mul/div/store with raw product
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       i_op,
  input  logic [3:0]       i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_ovf,
  output logic [WIDTH-1:0] o_prod
);

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_full;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_full = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
  assign o_prod = w_full[WIDTH-1:0];

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_ovf    = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_result = w_diff[WIDTH-1:0];
        o_ovf    = w_diff[WIDTH];
      end
      OP_MUL: begin
        o_result = w_full[WIDTH-1:0];
        o_ovf    = |w_full[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (i_b == '0) begin
          o_result = '1;
          o_ovf    = 1'b1;
        end else begin
          o_result = i_a / i_b;
        end
      end
      default: begin
        if (is_store(i_op, i_sub)) o_result = i_a;
      end
    endcase
  end

endmodule

// File: rtl/vec_alu_pipe.sv
// rtl/vec_alu_pipe.sv - two-stage stallable/flushable vector execute pipeline (X, X2)
module vec_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_pc,
  input  logic [15:0]            in_ins,
  input  logic [LANES*WIDTH-1:0] in_op1,
  input  logic [LANES*WIDTH-1:0] in_op2,
  input  logic                   flush,
  input  logic [LANES*WIDTH-1:0] x2_mem,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_ins,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [LANES-1:0]       out_ovf,
  output logic                   out_jump
);

  logic                   r_x_valid;
  logic [15:0]            r_x_pc;
  logic [15:0]            r_x_ins;
  logic [LANES*WIDTH-1:0] r_x_op1;
  logic [LANES*WIDTH-1:0] r_x_op2;
  logic                   r_x2_valid;
  logic [15:0]            r_x2_ins;
  logic [LANES*WIDTH-1:0] r_x2_res;
  logic [LANES-1:0]       r_x2_ovf;
  logic                   r_x2_jump;

  logic                        w_x2_adv;
  logic                        w_x_adv;
  logic [3:0]                  w_op;
  logic [3:0]                  w_sub;
  logic [LANES*WIDTH-1:0]      w_lane_res;
  logic [LANES-1:0]            w_lane_ovf;
  logic [LANES-1:0][WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]            w_dot;
  logic                        w_taken;
  logic [15:0]                 w_jtgt;
  logic [LANES*WIDTH-1:0]      w_res;
  logic [LANES-1:0]            w_ovf;
  logic                        w_jump;

  assign w_x2_adv = !r_x2_valid || out_ready;
  assign w_x_adv  = !r_x_valid || w_x2_adv;
  assign w_op     = r_x_ins[15:12];
  assign w_sub    = r_x_ins[7:4];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_alu_lane #(.WIDTH(WIDTH)) u_lane (
      .i_op     (w_op),
      .i_sub    (w_sub),
      .i_a      (r_x_op1[g*WIDTH +: WIDTH]),
      .i_b      (r_x_op2[g*WIDTH +: WIDTH]),
      .o_result (w_lane_res[g*WIDTH +: WIDTH]),
      .o_ovf    (w_lane_ovf[g]),
      .o_prod   (w_prod[g])
    );
  end

  always_comb begin
    w_dot = '0;
    for (int i = 0; i < LANES; i++) w_dot = w_dot + w_prod[i];
  end

  // Jump conditions look only at lane 0 of op1; target is lane 0 of op2.
  always_comb begin
    w_taken = 1'b0;
    case (w_sub)
      J_Z:     w_taken = (r_x_op1[WIDTH-1:0] == '0);
      J_NZ:    w_taken = (r_x_op1[WIDTH-1:0] != '0);
      J_S:     w_taken = r_x_op1[WIDTH-1];
      J_NS:    w_taken = !r_x_op1[WIDTH-1];
      default: w_taken = 1'b0;
    endcase
    w_jtgt = '0;
    if (w_taken) begin
      for (int b = 0; b < 16 && b < WIDTH; b++) w_jtgt[b] = r_x_op2[b];
    end else if (w_sub < 4'd4) begin
      w_jtgt = r_x_pc + 16'd2;
    end
  end

  always_comb begin
    w_res  = w_lane_res;
    w_ovf  = w_lane_ovf;
    w_jump = 1'b0;
    case (w_op)
      OP_DOT: begin
        w_res              = '0;
        w_res[WIDTH-1:0]   = w_dot;
        w_ovf              = '0;
      end
      OP_JMP: begin
        w_res  = '0;
        for (int b = 0; b < 16 && b < WIDTH; b++) w_res[b] = w_jtgt[b];
        w_ovf  = '0;
        w_jump = w_taken;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_valid  <= 1'b0;
      r_x_pc     <= '0;
      r_x_ins    <= '0;
      r_x_op1    <= '0;
      r_x_op2    <= '0;
      r_x2_valid <= 1'b0;
      r_x2_ins   <= '0;
      r_x2_res   <= '0;
      r_x2_ovf   <= '0;
      r_x2_jump  <= 1'b0;
    end else begin
      if (flush) r_x_valid <= 1'b0;
      else if (w_x_adv) r_x_valid <= in_valid;
      if (w_x_adv && in_valid && !flush) begin
        r_x_pc  <= in_pc;
        r_x_ins <= in_ins;
        r_x_op1 <= in_op1;
        r_x_op2 <= in_op2;
      end
      // A flushed X never reaches X2; X2 itself is left alone.
      if (w_x2_adv) begin
        r_x2_valid <= r_x_valid && !flush;
        if (r_x_valid && !flush) begin
          r_x2_ins  <= r_x_ins;
          r_x2_res  <= w_res;
          r_x2_ovf  <= w_ovf;
          r_x2_jump <= w_jump;
        end
      end
    end
  end

  assign in_ready   = w_x_adv;
  assign out_valid  = r_x2_valid;
  assign out_ins    = r_x2_ins;
  assign out_result = (r_x2_ins[15:12] == OP_LD) ? x2_mem : r_x2_res;
  assign out_ovf    = r_x2_ovf;
  assign out_jump   = r_x2_jump;

endmodule

// File: doc/vec_alu_pipe.md
# vec_alu_pipe

Parametrised two-stage execute pipeline for the vector core. It takes one decoded instruction per cycle from fetch/read, computes LANES independent WIDTH-bit arithmetic results plus scalar jump targets and the dot-product reduction, and merges load data in the second stage. Valid/ready handshakes on both sides and a squash input make it stallable and flushable, which the fixed two-stage ALU could not do. It feeds writeback and the PC-redirect logic.

## Interface
- LANES, 4: number of vector lanes (1..8)
- WIDTH, 16: lane data width (8..32); PC width is fixed at 16
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  pipeline accepts an instruction this cycle
- in_pc  in  16  instruction PC
- in_ins  in  16  instruction; opcode = [15:12], subcode = [7:4]
- in_op1, in_op2  in  LANES*WIDTH  operands; lane i = bits [i*WIDTH +: WIDTH]
- flush  in  1  squash X and any instruction accepted this cycle
- x2_mem  in  LANES*WIDTH  load data for the instruction in X2
- out_valid  out  1  X2 holds a result
- out_ready  in  1  downstream consumes the result
- out_ins  out  16  instruction in X2
- out_result  out  LANES*WIDTH  result
- out_ovf  out  LANES  per-lane overflow / divide-by-zero flag
- out_jump  out  1  X2 holds a jump and the jump is taken

## Operation
- Opcodes, per lane unless noted:
  - 0000 add: a+b; ovf = carry out.
  - 0001 sub: a-b; ovf = borrow.
  - 0010 mul: low WIDTH bits of a*b; ovf = high half ≠ 0.
  - 0011 div: unsigned a/b. If b=0, result = all ones and ovf = 1.
  - 1110 dot: sum over lanes of low-WIDTH products, mod 2^WIDTH, placed in lane 0; other lanes 0; ovf = 0 in every lane.
  - 0110 jump (lane 0 only):
    - Subcode 0 jz, 1 jnz, 2 js (op1 MSB = 1), 3 jns.
    - Taken: result = op2 low 16 bits, zero-extended.
    - Not taken: result = pc+2, mod 2^16.
    - Other lanes 0; out_jump = taken. An unknown subcode is never taken and gives result 0.
  - 0100, 1100, 1101 with subcode 1 (store): result = op1.
  - 0111 load: X2 output = x2_mem, ovf = 0.
  - Anything else: result 0, ovf 0.
- out_jump is 0 for every opcode except a taken jump.
- All arithmetic is computed in X and registered into X2. The load mux is combinational at the output.

## Timing
- Stages:
  - X: registered copy of the accepted input.
  - X2: registered result of X.
- Latency: an instruction accepted at edge N appears on out_valid/out_result after edge N+1, i.e. two edges in total.
- Handshake:
  - x2_adv = !x2_valid || out_ready
  - x_adv = !x_valid || x2_adv
  - in_ready = x_adv, combinational; there is no combinational in_valid→out_valid path.
- Transfers:
  - An input transfer is in_valid && in_ready. X2 loads from X when x_adv && x2_adv.
  - x2_valid clears when out_ready is high and X is empty or flushed.
  - Full throughput is one instruction per cycle with out_ready held high.
- Stall: while out_valid && !out_ready, out_ins, out_result, out_ovf and out_jump hold. The memory side holds x2_mem stable for a stalled load.
- Flush:
  - On an edge with flush = 1, x_valid ← 0 and a concurrent input transfer is discarded.
  - X2 is not affected: the jump already in X2 is the one that caused the flush.
  - flush has no effect on in_ready.
- Reset (async assert, sync deassert handled externally): x_valid = x2_valid = 0, all data registers 0. Outputs are therefore out_valid 0, out_result 0, out_ovf 0, out_jump 0, out_ins 0, in_ready 1.
- Reset mid-stall discards both stages.

## Structure
- Package vec_alu_pkg:
  - Opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SMEM, OP_JMP, OP_LD, OP_VLD, OP_VST, OP_DOT.
  - Jump subcodes J_Z, J_NZ, J_S, J_NS; SUB_ST = 1.
- Sub-module vec_alu_lane: combinational single-lane add/sub/mul/div/store producing result, ovf and raw product (for the dot sum). Instantiated LANES times via generate. Dot reduction and jump logic live in the top.

## Test plan
- LANES=4, WIDTH=16: add 0xFFFF+0x0001 in lane 2, 3+4 in the others → lane 2 result 0x0000, ovf[2]=1; others 7, ovf 0; out_valid two edges after accept.
- Div: op1 lanes {10,9,0,5}, op2 {3,0,7,0} → results {3,0xFFFF,0,0xFFFF}; out_ovf = 4'b1010.
- Dot: op1 {1,2,3,4}, op2 {5,6,7,8} → lane0 70, lanes1-3 0; then op1 = op2 = all 0x0100 → lane0 0, ovf 0.
- Jumps, pc=0x0040, op2=0x0100:
  - jz with op1=0 → result 0x0100, out_jump 1.
  - jnz with op1=0 → 0x0042, out_jump 0.
  - js with op1=0x8000 → taken.
  - Assert flush the cycle this jump is in X2 → the next instruction never appears.
- Back-pressure: stream 5 adds, hold out_ready low 3 cycles mid-stream → in_ready low after both stages fill, outputs stable, all 5 results in order with no duplicates or losses.
- Load: in_ins 0x7000, x2_mem lanes {0xAAAA,1,2,3} while in X2 → out_result equals x2_mem. Assert rst_n low mid-stall → out_valid 0 immediately and in_ready 1.
